// File: rtl/beta_mem_pkg.sv
// +----------------------------------------------------------------------+
// | beta_mem_pkg : shared types for the Beta data-memory write buffer     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package beta_mem_pkg;

    localparam int c_WB_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BUSY = 2'd1,
        ST_RD_BUSY = 2'd2
    } dmem_state_t;

    // Word address is kept zero-extended to 32 bits so the entry layout
    // does not depend on the top-level address width.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_entry_t;

    localparam int c_WB_ENTRY_W = $bits(wb_entry_t);

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// +----------------------------------------------------------------------+
// | wb_fifo : circular write buffer exposing every slot for forwarding    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic                          full,
    output logic                          empty,
    output logic [WIDTH-1:0]              head,
    output logic [DEPTH-1:0][WIDTH-1:0]   entries,
    output logic [DEPTH-1:0]              valid,
    output logic [$clog2(DEPTH)-1:0]      rd_ptr
);

    localparam int c_PW = $clog2(DEPTH);

    logic [c_PW-1:0]             r_wr_ptr;
    logic [c_PW-1:0]             r_rd_ptr;
    logic [c_PW:0]               r_count;
    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [DEPTH-1:0]            r_valid;
    logic                        w_push;
    logic                        w_pop;

    assign full  = r_count[c_PW];
    assign empty = (r_count == '0);
    assign w_pop  = pop && !empty;
    // A push into a full buffer is legal when the head leaves in the same cycle.
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop)  r_valid[r_rd_ptr] <= 1'b0;
            if (w_push) r_valid[r_wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign head    = r_mem[r_rd_ptr];
    assign entries = r_mem;
    assign valid   = r_valid;
    assign rd_ptr  = r_rd_ptr;

endmodule

`default_nettype wire

// File: rtl/dmem_write_buffer.sv
// +----------------------------------------------------------------------+
// | dmem_write_buffer : store buffer, load forwarding and SRAM sequencer  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_write_buffer
    import beta_mem_pkg::*;
#(
    parameter int DEPTH = c_WB_DEPTH,
    parameter int AW    = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_wr,
    input  logic [31:0]   mem_w_addr,
    input  logic [31:0]   mem_w_data,
    input  logic          mem_rd,
    input  logic [31:0]   mem_r_addr,
    output logic [31:0]   mem_r_data,
    output logic          mem_r_valid,
    output logic          stall,
    output logic          sram_req,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata,
    input  logic          sram_ack
);

    localparam int          c_PW    = $clog2(DEPTH);
    localparam logic [31:0] c_AMASK = 32'((64'd1 << AW) - 64'd1);

    dmem_state_t                        r_state;
    logic                               r_miss_done;
    logic [31:0]                        w_wr_word;
    logic [31:0]                        w_rd_word;
    logic                               w_full;
    logic                               w_empty;
    logic                               w_push;
    logic                               w_pop;
    logic [c_WB_ENTRY_W-1:0]            w_head_raw;
    logic [DEPTH-1:0][c_WB_ENTRY_W-1:0] w_entries;
    logic [DEPTH-1:0]                   w_valid;
    logic [c_PW-1:0]                    w_rd_ptr;
    wb_entry_t                          w_head;
    wb_entry_t                          w_new;
    logic                               w_st_req;
    logic                               w_st_cand;
    logic                               w_st_blocked;
    logic                               w_ld_req;
    logic                               w_buf_hit;
    logic [31:0]                        w_buf_data;
    logic                               w_fwd_hit;
    logic [31:0]                        w_fwd_data;
    logic                               w_ld_hit;
    logic                               w_ld_miss;
    logic                               w_unused;

    assign w_wr_word = {2'b00, mem_w_addr[31:2]} & c_AMASK;
    assign w_rd_word = {2'b00, mem_r_addr[31:2]} & c_AMASK;
    assign w_new     = '{addr: w_wr_word, data: mem_w_data};
    assign w_head    = wb_entry_t'(w_head_raw);
    assign w_pop     = (r_state == ST_WR_BUSY) && sram_ack;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_WB_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_new),
        .full    (w_full),
        .empty   (w_empty),
        .head    (w_head_raw),
        .entries (w_entries),
        .valid   (w_valid),
        .rd_ptr  (w_rd_ptr)
    );

    // Scan oldest to youngest so the last match found is the youngest.
    always_comb begin
        logic [c_PW-1:0] idx;
        wb_entry_t       ent;
        w_buf_hit  = 1'b0;
        w_buf_data = '0;
        idx        = '0;
        ent        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = w_rd_ptr + c_PW'(k);
            ent = wb_entry_t'(w_entries[idx]);
            if (w_valid[idx] && (ent.addr == w_rd_word)) begin
                w_buf_hit  = 1'b1;
                w_buf_data = ent.data;
            end
        end
    end

    // r_miss_done masks the held load in the cycle its miss data is returned.
    assign w_st_req     = !mem_wr;
    assign w_st_blocked = w_st_req && w_full;
    assign w_st_cand    = w_st_req && !w_full;
    assign w_ld_req     = !mem_rd && !r_miss_done;
    assign w_fwd_hit    = w_buf_hit || (w_st_cand && (w_wr_word == w_rd_word));
    assign w_fwd_data   = (w_st_cand && (w_wr_word == w_rd_word)) ? mem_w_data : w_buf_data;
    assign w_ld_hit     = w_ld_req && !w_st_blocked && w_fwd_hit;
    assign w_ld_miss    = w_ld_req && !w_st_blocked && !w_fwd_hit;
    // A store held behind a load miss is taken once the stall lifts, never twice.
    assign w_push       = w_st_cand && !w_ld_miss;
    assign stall        = !rst && (w_st_blocked || w_ld_miss);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r_data  <= '0;
            mem_r_valid <= 1'b0;
            r_miss_done <= 1'b0;
        end else begin
            mem_r_valid <= 1'b0;
            r_miss_done <= 1'b0;
            if ((r_state == ST_RD_BUSY) && sram_ack) begin
                mem_r_data  <= sram_rdata;
                mem_r_valid <= 1'b1;
                r_miss_done <= 1'b1;
            end else if (w_ld_hit) begin
                mem_r_data  <= w_fwd_data;
                mem_r_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            sram_req   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ld_miss) begin
                        r_state   <= ST_RD_BUSY;
                        sram_req  <= 1'b1;
                        sram_we   <= 1'b0;
                        sram_addr <= w_rd_word[AW-1:0];
                    end else if (!w_empty) begin
                        r_state    <= ST_WR_BUSY;
                        sram_req   <= 1'b1;
                        sram_we    <= 1'b1;
                        sram_addr  <= w_head.addr[AW-1:0];
                        sram_wdata <= w_head.data;
                    end
                end
                ST_WR_BUSY, ST_RD_BUSY: begin
                    if (sram_ack) begin
                        r_state  <= ST_IDLE;
                        sram_req <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    sram_req <= 1'b0;
                end
            endcase
        end
    end

    assign w_unused = ^{mem_w_addr[1:0], mem_r_addr[1:0], w_head.addr[31:AW], w_rd_word[31:AW]};

endmodule

`default_nettype wire

// File: tb/tb_dmem_write_buffer.sv
// +----------------------------------------------------------------------+
// | tb_dmem_write_buffer : directed bench with a behavioural SRAM         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dmem_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wr;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic        mem_rd;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_r_data;
    logic        mem_r_valid;
    logic        stall;
    logic        sram_req;
    logic        sram_we;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ack;

    int checks   = 0;
    int failures = 0;

    // SRAM model state and transaction log
    bit          ack_en;
    int          lat;
    int          cnt;
    logic [31:0] smem [logic [29:0]];
    bit          log_we   [$];
    logic [29:0] log_addr [$];
    logic [31:0] log_data [$];

    dmem_write_buffer #(.DEPTH(4), .AW(30)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_wr      (mem_wr),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .mem_rd      (mem_rd),
        .mem_r_addr  (mem_r_addr),
        .mem_r_data  (mem_r_data),
        .mem_r_valid (mem_r_valid),
        .stall       (stall),
        .sram_req    (sram_req),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .sram_ack    (sram_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sram_default(input logic [29:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rvalid(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_r_valid && n < max);
    endtask

    // Acks a request after lat cycles of req while enabled.
    initial begin
        sram_ack   = 1'b0;
        sram_rdata = '0;
        cnt        = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sram_ack = 1'b0;
                cnt      = 0;
            end else if (sram_ack) begin
                sram_ack = 1'b0;
                cnt      = 0;
            end else if (sram_req && ack_en) begin
                cnt++;
                if (cnt >= lat) begin
                    sram_ack = 1'b1;
                    log_we.push_back(sram_we);
                    log_addr.push_back(sram_addr);
                    if (sram_we) begin
                        smem[sram_addr] = sram_wdata;
                        log_data.push_back(sram_wdata);
                    end else begin
                        sram_rdata = smem.exists(sram_addr) ? smem[sram_addr] : sram_default(sram_addr);
                        log_data.push_back(sram_rdata);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int h;
        int bad;
        int base;

        mem_wr = 1'b1; mem_w_addr = '0; mem_w_data = '0;
        mem_rd = 1'b1; mem_r_addr = '0;
        ack_en = 1'b1; lat = 3;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_r_data",  mem_r_data,  32'h0);
        check("rst_r_valid", {31'h0, mem_r_valid}, 32'h0);
        check("rst_stall",   {31'h0, stall}, 32'h0);
        check("rst_sram_req", {31'h0, sram_req}, 32'h0);
        check("rst_sram_bus", {1'b0, sram_we, sram_addr} | sram_wdata, 32'h0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Reset while a write is outstanding
        ack_en = 1'b0; lat = 1;
        mem_wr = 1'b0; mem_w_addr = 32'h700; mem_w_data = 32'h77;
        tick();
        mem_wr = 1'b1;
        tick();
        check("rstmid_req_up", {31'h0, sram_req}, 32'h1);
        #2 rst = 1'b1;
        #1 check("rstmid_req_drop", {31'h0, sram_req}, 32'h0);
        @(negedge clk) rst = 1'b0;
        ack_en = 1'b1;
        tick();
        mem_rd = 1'b0; mem_r_addr = 32'h700;
        #1 check("rstmid_load_miss", {31'h0, stall}, 32'h1);
        wait_rvalid(20, n);
        check("rstmid_latency", n, 2);
        check("rstmid_data", mem_r_data, sram_default(30'h1C0));
        check("rstmid_no_write", log_we.size(), 1);
        mem_rd = 1'b1;
        tick();

        // Single store, ack three cycles after request
        lat = 3;
        base = log_we.size();
        mem_wr = 1'b0; mem_w_addr = 32'h100; mem_w_data = 32'hDEAD_BEEF;
        #1 check("st_no_stall", {31'h0, stall}, 32'h0);
        tick();
        mem_wr = 1'b1;
        n = 1;
        while (!sram_req && n < 10) begin
            tick();
            n++;
        end
        check("st_req_cycle", n, 2);
        check("st_we", {31'h0, sram_we}, 32'h1);
        check("st_addr", {2'b00, sram_addr}, 32'h40);
        check("st_wdata", sram_wdata, 32'hDEAD_BEEF);
        h = 0;
        while (sram_req && h < 20) begin
            h++;
            tick();
        end
        check("st_req_hold", h, 3);
        repeat (3) tick();
        check("st_dequeued", {31'h0, sram_req}, 32'h0);
        check("st_logged", {2'b00, log_addr[base]}, 32'h40);

        // Two stores to one word, then a forwarded load
        mem_wr = 1'b0; mem_w_addr = 32'h200; mem_w_data = 32'h1;
        tick();
        mem_w_data = 32'h2;
        tick();
        mem_wr = 1'b1;
        mem_rd = 1'b0; mem_r_addr = 32'h200;
        #1 check("hit_no_stall", {31'h0, stall}, 32'h0);
        tick();
        check("hit_valid", {31'h0, mem_r_valid}, 32'h1);
        check("hit_youngest", mem_r_data, 32'h2);
        mem_rd = 1'b1;
        tick();
        check("hit_pulse", {31'h0, mem_r_valid}, 32'h0);
        repeat (20) tick();

        // Store and load of the same word in one cycle
        mem_wr = 1'b0; mem_w_addr = 32'h300; mem_w_data = 32'hA5;
        mem_rd = 1'b0; mem_r_addr = 32'h300;
        #1 check("same_no_stall", {31'h0, stall}, 32'h0);
        tick();
        check("same_valid", {31'h0, mem_r_valid}, 32'h1);
        check("same_data", mem_r_data, 32'hA5);
        mem_wr = 1'b1; mem_rd = 1'b1;
        repeat (10) tick();

        // Fill the buffer with acks withheld
        ack_en = 1'b0; lat = 1;
        base = log_we.size();
        for (int i = 0; i < 4; i++) begin
            mem_wr = 1'b0; mem_w_addr = 32'h500 + 32'(4 * i); mem_w_data = 32'(i + 1);
            #1 check($sformatf("fill_%0d", i), {31'h0, stall}, 32'h0);
            tick();
        end
        mem_w_addr = 32'h510; mem_w_data = 32'h5;
        #1 check("full_stall", {31'h0, stall}, 32'h1);
        tick();
        check("full_stall_held", {31'h0, stall}, 32'h1);
        ack_en = 1'b1;
        tick();
        check("full_accept", {31'h0, stall}, 32'h0);
        tick();
        mem_wr = 1'b1;
        repeat (30) tick();
        check("full_drain_count", log_we.size(), base + 5);
        check("full_first_addr", {2'b00, log_addr[base]}, 32'h140);
        check("full_fifth_addr", {2'b00, log_addr[base + 4]}, 32'h144);
        check("full_fifth_data", log_data[base + 4], 32'h5);

        // Load miss behind an in-flight drain
        lat = 3;
        smem[30'h100] = 32'h1234_5678;
        base = log_we.size();
        mem_wr = 1'b0; mem_w_addr = 32'h600; mem_w_data = 32'h61;
        tick();
        mem_w_addr = 32'h604; mem_w_data = 32'h62;
        tick();
        mem_wr = 1'b1;
        mem_rd = 1'b0; mem_r_addr = 32'h400;
        #1 check("miss_stall", {31'h0, stall}, 32'h1);
        check("miss_drain_busy", {30'h0, sram_req, sram_we}, 32'h3);
        n = 0; bad = 0;
        do begin
            tick();
            n++;
            if (!mem_r_valid && !stall) bad++;
        end while (!mem_r_valid && n < 40);
        check("miss_latency", n, 7);
        check("miss_stall_held", bad, 0);
        check("miss_data", mem_r_data, 32'h1234_5678);
        check("miss_release", {31'h0, stall}, 32'h0);
        mem_rd = 1'b1;
        tick();
        check("miss_pulse", {31'h0, mem_r_valid}, 32'h0);
        repeat (20) tick();
        check("miss_order_cnt", log_we.size(), base + 3);
        check("miss_order_rd", {1'b0, log_we[base + 1], log_addr[base + 1]}, 32'h100);
        check("miss_order_wr", {2'b00, log_addr[base + 2]}, 32'h181);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
